// File: rtl/gsim_pkg.sv
// Shared constants and state encoding for the GSIM solver front end.
package gsim_pkg;

  localparam int unsigned N_UNK      = 16;
  localparam int unsigned B_W        = 16;
  localparam int unsigned X_W        = 32;
  localparam int unsigned FIFO_DEPTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StWait,
    StDrain
  } feed_state_e;

endpackage

// File: rtl/gsim_b_feeder_if.sv
// Host b-word stream plus the feeder <-> GSIM data path.
interface gsim_b_feeder_if #(
  parameter int unsigned B_W = 16
);

  logic           s_valid;
  logic [B_W-1:0] s_data;
  logic           s_last;
  logic           s_ready;
  logic           in_en;
  logic [B_W-1:0] b_in;
  logic           gsim_out_valid;

  modport master (
    output s_valid, s_data, s_last, gsim_out_valid,
    input  s_ready, in_en, b_in
  );

  modport slave (
    input  s_valid, s_data, s_last, gsim_out_valid,
    output s_ready, in_en, b_in
  );

endinterface

// File: rtl/gsim_sync_fifo.sv
// Synchronous FIFO with level count and a registered read port that reads 0 when not popping.
module gsim_sync_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  rd_data_q;
  logic          rd_valid_q;
  logic          push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    level_d = level_q;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage is not reset; emptiness is defined by the pointers and level alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q    <= level_d;
      rd_data_q  <= pop_ok ? mem_q[rd_ptr_q] : '0;
      rd_valid_q <= pop_ok;
    end
  end

  assign level    = level_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/gsim_b_feeder.sv
// Buffers host b-words and hands GSIM one 16-word frame per solve, then waits out the results.
module gsim_b_feeder #(
  parameter int unsigned N_UNK      = gsim_pkg::N_UNK,
  parameter int unsigned B_W        = gsim_pkg::B_W,
  parameter int unsigned FIFO_DEPTH = gsim_pkg::FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  gsim_b_feeder_if.slave              bus,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 frames_sent,
  output logic                        err_frame,
  output logic                        err_proto
);

  import gsim_pkg::*;

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW = $clog2(N_UNK);
  localparam logic [CW-1:0] LastIdx    = CW'(N_UNK - 1);
  localparam logic [LW-1:0] FrameLevel = LW'(N_UNK);

  feed_state_e   state_q, state_d;
  logic [CW-1:0] feed_cnt_q, res_cnt_q, host_cnt_q;
  logic [15:0]   frames_q;
  logic          last_word_q;
  logic          err_frame_q, err_proto_q;

  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] level;
  logic          gov;

  assign gov  = bus.gsim_out_valid;
  assign push = bus.s_valid && !fifo_full;

  gsim_sync_fifo #(
    .W     (B_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .wr_data  (bus.s_data),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level),
    .rd_data  (bus.b_in),
    .rd_valid (bus.in_en)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (level >= FrameLevel)          state_d = StFeed;
      StFeed:  if (feed_cnt_q == LastIdx)        state_d = StWait;
      StWait:  if (gov)                          state_d = StDrain;
      StDrain: if (gov && res_cnt_q == LastIdx)  state_d = StIdle;
      default:                                   state_d = StIdle;
    endcase
  end

  always_comb begin
    pop  = (state_q == StFeed) && !fifo_empty;
    busy = (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      feed_cnt_q  <= '0;
      res_cnt_q   <= '0;
      host_cnt_q  <= '0;
      frames_q    <= '0;
      last_word_q <= 1'b0;
      err_frame_q <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      if (pop) feed_cnt_q <= (feed_cnt_q == LastIdx) ? '0 : feed_cnt_q + CW'(1);

      // The out_valid cycle that leaves WAIT is already result number one.
      if (state_q == StWait && gov) begin
        res_cnt_q <= CW'(1);
      end else if (state_q == StDrain && gov) begin
        res_cnt_q <= (res_cnt_q == LastIdx) ? '0 : res_cnt_q + CW'(1);
      end

      if (push) begin
        host_cnt_q <= (host_cnt_q == LastIdx) ? '0 : host_cnt_q + CW'(1);
        if (bus.s_last != (host_cnt_q == LastIdx)) err_frame_q <= 1'b1;
      end

      if (gov && (state_q == StIdle || state_q == StFeed)) err_proto_q <= 1'b1;

      // last_word_q marks the cycle the final word sits on b_in; count the frame after it.
      last_word_q <= pop && (feed_cnt_q == LastIdx);
      if (last_word_q) frames_q <= frames_q + 16'd1;
    end
  end

  assign bus.s_ready = !fifo_full;
  assign fifo_level  = level;
  assign frames_sent = frames_q;
  assign err_frame   = err_frame_q;
  assign err_proto   = err_proto_q;

endmodule

// File: tb/tb_gsim_b_feeder.sv
// Directed bench for gsim_b_feeder: framing, FIFO full/back-pressure, result drain, errors, reset.
module tb_gsim_b_feeder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gsim_b_feeder_if #(.B_W(16)) bus ();

  logic        busy;
  logic [5:0]  fifo_level;
  logic [15:0] frames_sent;
  logic        err_frame;
  logic        err_proto;

  gsim_b_feeder #(
    .N_UNK      (16),
    .B_W        (16),
    .FIFO_DEPTH (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .frames_sent (frames_sent),
    .err_frame   (err_frame),
    .err_proto   (err_proto)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] got_q [$];
  int          cyc_q [$];
  logic [15:0] exp_q [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_en) begin
      got_q.push_back(bus.b_in);
      cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic push_word(input logic [15:0] d, input logic l);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("push_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic drive_results(input int n);
    repeat (n) begin
      bus.gsim_out_valid = 1'b1;
      @(negedge clk);
    end
    bus.gsim_out_valid = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (got_q.size() < 16 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() < 16) begin
      check({tag, "_timeout"}, 32'(got_q.size()), 32'd16);
      got_q.delete();
      cyc_q.delete();
      exp_q.delete();
    end else begin
      check({tag, "_contig"}, 32'(cyc_q[15] - cyc_q[0]), 32'd15);
      for (int i = 0; i < 16; i++) check($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      repeat (16) begin
        void'(got_q.pop_front());
        void'(cyc_q.pop_front());
        void'(exp_q.pop_front());
      end
    end
  endtask

  initial begin
    int n;
    bus.s_valid        = 1'b0;
    bus.s_data         = '0;
    bus.s_last         = 1'b0;
    bus.gsim_out_valid = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);

    check("rst_in_en", 32'(bus.in_en), 32'd0);
    check("rst_b_in", 32'(bus.b_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    check("rst_err_frame", 32'(err_frame), 32'd0);
    check("rst_err_proto", 32'(err_proto), 32'd0);
    check("rst_s_ready", 32'(bus.s_ready), 32'd1);

    // Frame 1: 0x0001..0x0010
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(16'(i + 1));
      push_word(16'(i + 1), i == 15);
    end
    wait_frame("f1");
    idle(2);
    check("f1_frames", 32'(frames_sent), 32'd1);
    check("f1_busy_wait", 32'(busy), 32'd1);
    check("f1_in_en_low", 32'(bus.in_en), 32'd0);
    check("f1_level", 32'(fifo_level), 32'd0);
    drive_results(15);
    check("f1_busy_15res", 32'(busy), 32'd1);
    drive_results(1);
    check("f1_busy_done", 32'(busy), 32'd0);
    check("f1_err_proto", 32'(err_proto), 32'd0);
    check("f1_err_frame", 32'(err_frame), 32'd0);

    // Frame 2: 15 words do not start a feed, the 16th does
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(16'h0100 + 16'(i));
      push_word(16'h0100 + 16'(i), 1'b0);
    end
    idle(4);
    check("p15_in_en", 32'(bus.in_en), 32'd0);
    check("p15_busy", 32'(busy), 32'd0);
    check("p15_level", 32'(fifo_level), 32'd15);
    check("p15_nowords", 32'(got_q.size()), 32'd0);
    exp_q.push_back(16'h010F);
    push_word(16'h010F, 1'b1);
    n = 0;
    while (!bus.in_en && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("feed_latency", 32'(n), 32'd2);
    wait_frame("f2");

    // Still in WAIT: 32 words fill the FIFO, 8 more back up behind it
    for (int i = 0; i < 32; i++) push_word(16'h0200 + 16'(i), (i % 16) == 15);
    check("full_level", 32'(fifo_level), 32'd32);
    check("full_s_ready", 32'(bus.s_ready), 32'd0);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h0220;
    idle(3);
    check("full_hold_level", 32'(fifo_level), 32'd32);
    for (int i = 0; i < 32; i++) exp_q.push_back(16'h0200 + 16'(i));
    fork
      for (int i = 32; i < 40; i++) push_word(16'h0200 + 16'(i), 1'b0);
      drive_results(16);
    join
    wait_frame("f3");
    drive_results(16);
    wait_frame("f4");
    drive_results(16);
    check("f4_busy", 32'(busy), 32'd0);
    check("f4_level", 32'(fifo_level), 32'd8);
    check("f4_frames", 32'(frames_sent), 32'd4);
    check("f4_err_frame", 32'(err_frame), 32'd0);
    check("f4_err_proto", 32'(err_proto), 32'd0);

    // Misplaced s_last (host index 10) still yields a 16-word frame
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h0220 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(16'h0300 + 16'(i));
      push_word(16'h0300 + 16'(i), i == 2);
    end
    check("f5_err_frame", 32'(err_frame), 32'd1);
    n = 0;
    while (!bus.in_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("f5_feed_seen", 32'(bus.in_en), 32'd1);
    check("f5_err_proto_pre", 32'(err_proto), 32'd0);
    drive_results(1);
    check("f5_err_proto", 32'(err_proto), 32'd1);
    wait_frame("f5");
    idle(2);
    check("f5_frames", 32'(frames_sent), 32'd5);
    drive_results(5);
    idle(3);
    drive_results(10);
    idle(2);
    check("gap_busy_15", 32'(busy), 32'd1);
    drive_results(1);
    check("gap_busy_done", 32'(busy), 32'd0);
    check("f5_err_frame_sticky", 32'(err_frame), 32'd1);
    check("f5_err_proto_sticky", 32'(err_proto), 32'd1);

    // Reset on the 8th in_en cycle of frame 6
    for (int i = 0; i < 16; i++) push_word(16'h0400 + 16'(i), i == 15);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.in_en) n++;
      if (n == 8) break;
      @(negedge clk);
    end
    check("r6_en_count", 32'(n), 32'd8);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("r6_in_en", 32'(bus.in_en), 32'd0);
    check("r6_b_in", 32'(bus.b_in), 32'd0);
    check("r6_level", 32'(fifo_level), 32'd0);
    check("r6_frames", 32'(frames_sent), 32'd0);
    check("r6_s_ready", 32'(bus.s_ready), 32'd1);
    check("r6_busy", 32'(busy), 32'd0);
    check("r6_err_frame", 32'(err_frame), 32'd0);
    check("r6_err_proto", 32'(err_proto), 32'd0);
    got_q.delete();
    cyc_q.delete();
    idle(3);
    check("r6_no_feed", 32'(got_q.size()), 32'd0);
    check("r6_busy_after", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
